// File: rtl/msrv32_wr_en_ctrl.sv
// msrv32_wr_en_ctrl: qualifies per-channel register-file write enables
// against flush/stall and a post-flush shadow window, and counts commits.
module msrv32_wr_en_ctrl #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 5,
    parameter int SHADOW = 1,
    parameter int CNT_W  = 16
) (
    input  logic                      ms_riscv32_mp_clk_in,
    input  logic                      ms_riscv32_mp_rst_n_in,
    input  logic                      flush_in,
    input  logic                      stall_in,
    input  logic [NUM_CH-1:0]         wr_en_reg_in,
    input  logic [NUM_CH*ADDR_W-1:0]  wr_addr_in,
    output logic [NUM_CH-1:0]         wr_en_out,
    output logic [NUM_CH*ADDR_W-1:0]  wr_addr_out,
    output logic                      shadow_active_out,
    output logic [NUM_CH*CNT_W-1:0]   commit_cnt_out
);

    typedef enum logic {
        ST_RUN,
        ST_SHADOW
    } state_t;

    localparam logic [3:0] SHADOW_LD = 4'(SHADOW);

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          shadow_cnt_q;
    logic [3:0]          shadow_cnt_d;
    logic [NUM_CH-1:0]   qual_en;

    // A write may only commit in RUN with no flush or stall this cycle.
    always_comb begin
        qual_en = wr_en_reg_in
                & {NUM_CH{~flush_in & ~stall_in & (state_q == ST_RUN)}};
    end

    // Shadow window sequencing; a flush restarts the window from the top.
    always_comb begin
        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush_in && (SHADOW > 0)) begin
                    state_d      = ST_SHADOW;
                    shadow_cnt_d = SHADOW_LD;
                end
            end
            ST_SHADOW: begin
                if (flush_in) begin
                    shadow_cnt_d = SHADOW_LD;
                end else if (shadow_cnt_q == 4'd1) begin
                    state_d      = ST_RUN;
                    shadow_cnt_d = 4'd0;
                end else begin
                    shadow_cnt_d = shadow_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d      = ST_RUN;
                shadow_cnt_d = 4'd0;
            end
        endcase
    end

    // FSM state, shadow counter and registered shadow indicator.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q           <= ST_RUN;
            shadow_cnt_q      <= 4'd0;
            shadow_active_out <= 1'b0;
        end else begin
            state_q           <= state_d;
            shadow_cnt_q      <= shadow_cnt_d;
            shadow_active_out <= (state_d == ST_SHADOW);
        end
    end

    // Enables register every cycle; addresses and counters move only on commit.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            wr_en_out      <= '0;
            wr_addr_out    <= '0;
            commit_cnt_out <= '0;
        end else begin
            wr_en_out <= qual_en;
            for (int i = 0; i < NUM_CH; i++) begin
                if (qual_en[i]) begin
                    wr_addr_out[i*ADDR_W +: ADDR_W] <=
                        wr_addr_in[i*ADDR_W +: ADDR_W];
                    commit_cnt_out[i*CNT_W +: CNT_W] <=
                        commit_cnt_out[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_msrv32_wr_en_ctrl.sv
// tb_msrv32_wr_en_ctrl: scoreboard bench for msrv32_wr_en_ctrl
// (2 channels, 5-bit addresses, 2-cycle shadow, 4-bit counters).
module tb_msrv32_wr_en_ctrl;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 5;
    localparam int SHADOW = 2;
    localparam int CNT_W  = 4;

    logic        clk;
    logic        rst_n;
    logic        flush_in;
    logic        stall_in;
    logic [1:0]  wr_en_reg_in;
    logic [9:0]  wr_addr_in;
    logic [1:0]  wr_en_out;
    logic [9:0]  wr_addr_out;
    logic        shadow_active_out;
    logic [7:0]  commit_cnt_out;

    typedef struct {
        logic [1:0] en;
        logic [9:0] addr;
        logic       sh;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] m_addr;
    logic [3:0] m_cnt0;
    logic [3:0] m_cnt1;
    int         m_sh;

    msrv32_wr_en_ctrl #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .SHADOW (SHADOW),
        .CNT_W  (CNT_W)
    ) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .flush_in               (flush_in),
        .stall_in               (stall_in),
        .wr_en_reg_in           (wr_en_reg_in),
        .wr_addr_in             (wr_addr_in),
        .wr_en_out              (wr_en_out),
        .wr_addr_out            (wr_addr_out),
        .shadow_active_out      (shadow_active_out),
        .commit_cnt_out         (commit_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.en   = 2'b00;
        e.addr = m_addr;
        e.sh   = (m_sh != 0);
        e.cnt  = {m_cnt1, m_cnt0};
        return e;
    endfunction

    task automatic model_reset();
        m_addr = '0;
        m_cnt0 = '0;
        m_cnt1 = '0;
        m_sh   = 0;
    endtask

    task automatic model_edge(input logic [1:0] en, input logic [9:0] addr,
                              input logic fl, input logic st,
                              output exp_t e);
        logic [1:0] q;
        q = (!fl && !st && m_sh == 0) ? en : 2'b00;
        if (q[0]) begin
            m_addr[4:0] = addr[4:0];
            m_cnt0      = m_cnt0 + 4'd1;
        end
        if (q[1]) begin
            m_addr[9:5] = addr[9:5];
            m_cnt1      = m_cnt1 + 4'd1;
        end
        if (fl) m_sh = SHADOW;
        else if (m_sh > 0) m_sh = m_sh - 1;
        e = model_now();
        e.en = q;
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_en"},   32'(wr_en_out),         32'(e.en));
        check({tag, "_addr"}, 32'(wr_addr_out),       32'(e.addr));
        check({tag, "_sh"},   32'(shadow_active_out), 32'(e.sh));
        check({tag, "_cnt"},  32'(commit_cnt_out),    32'(e.cnt));
    endtask

    task automatic step(input string tag, input logic [1:0] en,
                        input logic [9:0] addr, input logic fl,
                        input logic st);
        exp_t e;
        wr_en_reg_in = en;
        wr_addr_in   = addr;
        flush_in     = fl;
        stall_in     = st;
        model_edge(en, addr, fl, st, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    localparam logic [9:0] A73 = {5'd7, 5'd3};
    localparam logic [9:0] A94 = {5'd9, 5'd4};

    initial begin
        rst_n        = 1'b0;
        flush_in     = 1'b0;
        stall_in     = 1'b0;
        wr_en_reg_in = 2'b00;
        wr_addr_in   = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        sb.push_back(model_now());
        compare_out("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // steady dual-channel writes
        step("run0", 2'b11, A73, 1'b0, 1'b0);
        check("run0_lit_addr", 32'(wr_addr_out), 32'(A73));
        check("run0_lit_en", 32'(wr_en_out), 32'd3);
        step("run1", 2'b11, A73, 1'b0, 1'b0);
        step("run2", 2'b11, A73, 1'b0, 1'b0);
        check("run2_lit_cnt", 32'(commit_cnt_out), 32'h33);

        // single-cycle flush: 3 suppressed cycles, 2 shadow cycles
        step("fl0", 2'b11, A73, 1'b1, 1'b0);
        check("fl0_lit_sh", 32'(shadow_active_out), 32'd1);
        step("fl1", 2'b11, A73, 1'b0, 1'b0);
        check("fl1_lit_en", 32'(wr_en_out), 32'd0);
        step("fl2", 2'b11, A73, 1'b0, 1'b0);
        check("fl2_lit_sh", 32'(shadow_active_out), 32'd0);
        step("fl3", 2'b11, A73, 1'b0, 1'b0);
        check("fl3_lit_en", 32'(wr_en_out), 32'd3);

        // stall holds address and counters
        for (int i = 0; i < 3; i++) step("stall", 2'b11, A94, 1'b0, 1'b1);
        check("stall_lit_addr", 32'(wr_addr_out), 32'(A73));
        step("unstall0", 2'b11, A94, 1'b0, 1'b0);
        check("unstall_lit_addr", 32'(wr_addr_out), 32'(A94));
        step("unstall1", 2'b11, A94, 1'b0, 1'b0);

        // flush+stall, then a re-flush inside the shadow window
        step("fs0", 2'b11, A73, 1'b1, 1'b1);
        step("fs1", 2'b11, A73, 1'b0, 1'b0);
        step("fs2", 2'b11, A73, 1'b1, 1'b0);
        check("fs2_lit_sh", 32'(shadow_active_out), 32'd1);
        step("fs3", 2'b11, A73, 1'b0, 1'b0);
        step("fs4", 2'b11, A73, 1'b0, 1'b0);
        check("fs4_lit_en", 32'(wr_en_out), 32'd0);
        step("fs5", 2'b11, A73, 1'b0, 1'b0);
        check("fs5_lit_en", 32'(wr_en_out), 32'd3);

        // ch0-only commits, enough to wrap the 4-bit counter
        for (int i = 0; i < 17; i++)
            step("wrap", 2'b01, 10'(i), 1'b0, 1'b0);
        step("ch1only", 2'b10, {5'd21, 5'd30}, 1'b0, 1'b0);

        // random traffic
        for (int i = 0; i < 60; i++) begin
            step("rnd", 2'($urandom_range(0, 3)), 10'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0));
        end

        // async reset in the middle of a shadow window
        step("ar0", 2'b11, A94, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb.push_back(model_now());
        compare_out("ar_async");
        @(negedge clk);
        rst_n = 1'b1;
        step("ar1", 2'b11, A73, 1'b0, 1'b0);
        check("ar1_lit_en", 32'(wr_en_out), 32'd3);
        step("ar2", 2'b11, A73, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
